bip_cpu_ext: RTL and testbench

Second-generation BIP accumulator CPU. It keeps the BIP fetch/execute model: a PC addresses instruction memory, and a single accumulator (ACC) is operated on with immediate or data-memory operands. It adds logic, shift and branch opcodes, a HALT state, and a ready-based data-memory handshake so slow RAMs can stall the core. It sits between instruction memory and data RAM in the top-level system, replacing the fixed-timing core.

---
 rtl/bip_cpu_ext_pkg.sv | 93 +++++++++
 rtl/bip_alu_ext.sv | 29 ++
 rtl/bip_cpu_ext.sv | 181 ++++++++++++++++++
 tb/tb_bip_cpu_ext.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/bip_cpu_ext_pkg.sv
// Shared ISA definitions for the second-generation BIP accumulator CPU:
// field widths, opcodes, FSM state encodings, ALU op codes and the
// opcode classification helpers used by the core's decoder.
package bip_cpu_ext_pkg;

  localparam int NB_DATA            = 16;
  localparam int NB_OPCODE          = 5;
  localparam int NB_OPERAND         = NB_DATA - NB_OPCODE;
  localparam int LOG2_N_INSMEM_ADDR = 11;
  localparam int LOG2_N_DATA_ADDR   = 10;
  localparam int NB_SHAMT           = 4;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [4:0] OP_AND  = 5'b01000;
  localparam logic [4:0] OP_ANDI = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ORI  = 5'b01011;
  localparam logic [4:0] OP_XOR  = 5'b01100;
  localparam logic [4:0] OP_XORI = 5'b01101;
  localparam logic [4:0] OP_SLL  = 5'b01110;
  localparam logic [4:0] OP_SRL  = 5'b01111;
  localparam logic [4:0] OP_SRA  = 5'b10000;
  localparam logic [4:0] OP_BEQ  = 5'b10001;
  localparam logic [4:0] OP_BNE  = 5'b10010;
  localparam logic [4:0] OP_JMP  = 5'b10011;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MEM  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [3:0] ALU_PASS = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;

  // Register-form ops that need a data RAM access before completing.
  function automatic logic is_mem_op(input logic [4:0] op);
    case (op)
      OP_STO, OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: is_mem_op = 1'b1;
      default:                                             is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_branch(input logic [4:0] op);
    case (op)
      OP_BEQ, OP_BNE, OP_JMP: is_branch = 1'b1;
      default:                is_branch = 1'b0;
    endcase
  endfunction

  // Single-cycle ops that write the accumulator from the immediate.
  function automatic logic is_imm_op(input logic [4:0] op);
    case (op)
      OP_LDI, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI,
      OP_SLL, OP_SRL, OP_SRA: is_imm_op = 1'b1;
      default:                is_imm_op = 1'b0;
    endcase
  endfunction

  // Both immediate and register forms of an op share one ALU function.
  function automatic logic [3:0] alu_op_of(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: alu_op_of = ALU_ADD;
      OP_SUB, OP_SUBI: alu_op_of = ALU_SUB;
      OP_AND, OP_ANDI: alu_op_of = ALU_AND;
      OP_OR,  OP_ORI:  alu_op_of = ALU_OR;
      OP_XOR, OP_XORI: alu_op_of = ALU_XOR;
      OP_SLL:          alu_op_of = ALU_SLL;
      OP_SRL:          alu_op_of = ALU_SRL;
      OP_SRA:          alu_op_of = ALU_SRA;
      default:         alu_op_of = ALU_PASS;
    endcase
  endfunction

  function automatic logic [NB_DATA-1:0] sext_imm(input logic [NB_OPERAND-1:0] x);
    sext_imm = {{(NB_DATA-NB_OPERAND){x[NB_OPERAND-1]}}, x};
  endfunction

endpackage

// File: rtl/bip_alu_ext.sv
// Combinational accumulator ALU: result = op(a, b) or a shifted by shamt.
module bip_alu_ext
  import bip_cpu_ext_pkg::*;
(
  input  logic [3:0]          op,
  input  logic [NB_DATA-1:0]  a,
  input  logic [NB_DATA-1:0]  b,
  input  logic [NB_SHAMT-1:0] shamt,
  output logic [NB_DATA-1:0]  result
);

  // Select the arithmetic, logic, pass or shift result.
  always_comb begin
    result = b;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_PASS: result = b;
      default:  result = b;
    endcase
  end

endmodule

// File: rtl/bip_cpu_ext.sv
// BIP accumulator CPU with RUN/MEM/HALT control, ready-stalled data RAM
// accesses and registered memory strobes.
module bip_cpu_ext
  import bip_cpu_ext_pkg::*;
(
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_valid,
  input  logic [NB_DATA-1:0]            i_instruction,
  input  logic [NB_DATA-1:0]            i_data_mem,
  input  logic                          i_mem_ready,
  output logic [LOG2_N_INSMEM_ADDR-1:0] o_addr_instr,
  output logic [LOG2_N_DATA_ADDR-1:0]   o_addr_data,
  output logic [NB_DATA-1:0]            o_data,
  output logic                          o_wr_ram,
  output logic                          o_rd_ram,
  output logic [NB_DATA-1:0]            o_acc,
  output logic                          o_halt
);

  state_t state, state_next;
  logic [LOG2_N_INSMEM_ADDR-1:0] pc, pc_next;
  logic [NB_DATA-1:0]            acc, acc_next;
  // Only the opcode and data address of a memory instruction are kept.
  logic [NB_OPCODE-1:0]          ir_op, ir_op_next;
  logic [LOG2_N_DATA_ADDR-1:0]   ir_addr, ir_addr_next;

  logic [NB_OPCODE-1:0]  run_op;
  logic [NB_OPERAND-1:0] run_operand;
  logic [3:0]            alu_op;
  logic [NB_DATA-1:0]    alu_b, alu_result;
  logic                  rd_next, wr_next, halt_next;
  logic [LOG2_N_DATA_ADDR-1:0] addr_data_next;
  logic [NB_DATA-1:0]    data_next;

  assign run_op      = i_instruction[NB_DATA-1 -: NB_OPCODE];
  assign run_operand = i_instruction[NB_OPERAND-1:0];

  // In MEM the ALU combines ACC with RAM data; in RUN with the immediate.
  assign alu_op = (state == ST_MEM) ? alu_op_of(ir_op) : alu_op_of(run_op);
  assign alu_b  = (state == ST_MEM) ? i_data_mem : sext_imm(run_operand);

  bip_alu_ext u_alu (
    .op     (alu_op),
    .a      (acc),
    .b      (alu_b),
    .shamt  (run_operand[NB_SHAMT-1:0]),
    .result (alu_result)
  );

  // State register; reset wins over the clock enable.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; transitions happen only on enabled edges.
  always_comb begin
    state_next = state;
    if (i_valid) begin
      case (state)
        ST_RUN: begin
          if (run_op == OP_HLT) begin
            state_next = ST_HALT;
          end else if (is_mem_op(run_op)) begin
            state_next = ST_MEM;
          end else begin
            state_next = ST_RUN;
          end
        end
        ST_MEM:  state_next = i_mem_ready ? ST_RUN : ST_MEM;
        ST_HALT: state_next = ST_HALT;
        default: state_next = ST_RUN;
      endcase
    end else begin
      state_next = state;
    end
  end

  // PC, ACC and IR update for the current state and instruction.
  always_comb begin
    pc_next      = pc;
    acc_next     = acc;
    ir_op_next   = ir_op;
    ir_addr_next = ir_addr;
    if (i_valid) begin
      case (state)
        ST_RUN: begin
          if (run_op == OP_HLT) begin
            pc_next = pc;
          end else if (is_mem_op(run_op)) begin
            ir_op_next   = run_op;
            ir_addr_next = run_operand[LOG2_N_DATA_ADDR-1:0];
          end else if (is_branch(run_op)) begin
            if ((run_op == OP_JMP) ||
                ((run_op == OP_BEQ) && (acc == {NB_DATA{1'b0}})) ||
                ((run_op == OP_BNE) && (acc != {NB_DATA{1'b0}}))) begin
              pc_next = run_operand[LOG2_N_INSMEM_ADDR-1:0];
            end else begin
              pc_next = pc + 11'd1;
            end
          end else if (is_imm_op(run_op)) begin
            acc_next = alu_result;
            pc_next  = pc + 11'd1;
          end else begin
            pc_next = pc + 11'd1;
          end
        end
        ST_MEM: begin
          if (i_mem_ready) begin
            pc_next = pc + 11'd1;
            if (ir_op != OP_STO) begin
              acc_next = alu_result;
            end else begin
              acc_next = acc;
            end
          end else begin
            pc_next = pc;
          end
        end
        ST_HALT: pc_next = pc;
        default: pc_next = pc;
      endcase
    end else begin
      pc_next = pc;
    end
  end

  // Next registered outputs, decoded from the upcoming state so strobes
  // never follow i_instruction combinationally.
  always_comb begin
    rd_next        = 1'b0;
    wr_next        = 1'b0;
    addr_data_next = {LOG2_N_DATA_ADDR{1'b0}};
    data_next      = {NB_DATA{1'b0}};
    halt_next      = (state_next == ST_HALT);
    if (state_next == ST_MEM) begin
      addr_data_next = ir_addr_next;
      if (ir_op_next == OP_STO) begin
        wr_next   = 1'b1;
        data_next = acc_next;
      end else begin
        rd_next = 1'b1;
      end
    end else begin
      rd_next = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      pc          <= 11'd0;
      acc         <= 16'd0;
      ir_op       <= 5'd0;
      ir_addr     <= 10'd0;
      o_rd_ram    <= 1'b0;
      o_wr_ram    <= 1'b0;
      o_addr_data <= 10'd0;
      o_data      <= 16'd0;
      o_halt      <= 1'b0;
    end else begin
      pc          <= pc_next;
      acc         <= acc_next;
      ir_op       <= ir_op_next;
      ir_addr     <= ir_addr_next;
      o_rd_ram    <= rd_next;
      o_wr_ram    <= wr_next;
      o_addr_data <= addr_data_next;
      o_data      <= data_next;
      o_halt      <= halt_next;
    end
  end

  assign o_addr_instr = pc;
  assign o_acc        = acc;

endmodule

// File: tb/tb_bip_cpu_ext.sv
// Directed bench for bip_cpu_ext: each step drives one cycle of inputs,
// queues the expected post-edge outputs and compares them after the edge.
module tb_bip_cpu_ext;

  localparam logic [4:0] HLT = 5'b00000, STO = 5'b00001, LD = 5'b00010,
                         LDI = 5'b00011, ADDI = 5'b00101, SUBI = 5'b00111,
                         ADD = 5'b00100, SUB = 5'b00110, AND = 5'b01000,
                         ORI = 5'b01011, XORI = 5'b01101, SLL = 5'b01110,
                         SRL = 5'b01111, SRA = 5'b10000, BEQ = 5'b10001,
                         BNE = 5'b10010, JMP = 5'b10011, NOP = 5'b11111;

  logic        clock = 1'b0;
  logic        reset, valid, mem_ready;
  logic [15:0] instruction, data_mem;
  logic [10:0] addr_instr;
  logic [9:0]  addr_data;
  logic [15:0] data, acc;
  logic        wr_ram, rd_ram, halt;

  typedef struct packed {
    logic [10:0] pc;
    logic [15:0] acc;
    logic        halt;
    logic        rd;
    logic        wr;
    logic [9:0]  addr;
    logic [15:0] data;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  bip_cpu_ext dut (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_valid       (valid),
    .i_instruction (instruction),
    .i_data_mem    (data_mem),
    .i_mem_ready   (mem_ready),
    .o_addr_instr  (addr_instr),
    .o_addr_data   (addr_data),
    .o_data        (data),
    .o_wr_ram      (wr_ram),
    .o_rd_ram      (rd_ram),
    .o_acc         (acc),
    .o_halt        (halt)
  );

  function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] opnd);
    return {op, opnd};
  endfunction

  function automatic obs_t mk(input logic [10:0] pc, input logic [15:0] a,
                              input logic h, input logic r, input logic w,
                              input logic [9:0] ad, input logic [15:0] d);
    obs_t e;
    e.pc = pc; e.acc = a; e.halt = h; e.rd = r; e.wr = w; e.addr = ad; e.data = d;
    return e;
  endfunction

  task automatic step(input string tag, input logic rst, input logic v,
                      input logic [15:0] instr, input logic rdy,
                      input logic [15:0] dm, input obs_t e);
    obs_t got, want;
    reset = rst; valid = v; instruction = instr; mem_ready = rdy; data_mem = dm;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    got  = {addr_instr, acc, halt, rd_ram, wr_ram, addr_data, data};
    want = exp_q.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed pc=%h acc=%h halt=%b rd=%b wr=%b addr=%h data=%h expected pc=%h acc=%h halt=%b rd=%b wr=%b addr=%h data=%h",
             tag, got.pc, got.acc, got.halt, got.rd, got.wr, got.addr, got.data,
             want.pc, want.acc, want.halt, want.rd, want.wr, want.addr, want.data);
    end
  endtask

  initial begin
    reset = 1'b0; valid = 1'b1; mem_ready = 1'b0;
    instruction = 16'h0000; data_mem = 16'h0000;
    #2;
    step("reset",      1'b0, 1'b1, ins(LDI, 11'd5), 1'b0, 16'h0, mk(11'd0, 16'h0, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    // immediate arithmetic
    step("ldi5",       1'b1, 1'b1, ins(LDI, 11'd5),    1'b0, 16'h0, mk(11'd1, 16'h0005, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("addi_m2",    1'b1, 1'b1, ins(ADDI, 11'h7FE), 1'b0, 16'h0, mk(11'd2, 16'h0003, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("subi10",     1'b1, 1'b1, ins(SUBI, 11'd10),  1'b0, 16'h0, mk(11'd3, 16'hFFF9, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    // logic and shifts
    step("ldi_f0",     1'b1, 1'b1, ins(LDI, 11'h0F0),  1'b0, 16'h0, mk(11'd4, 16'h00F0, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("xori_ff",    1'b1, 1'b1, ins(XORI, 11'h0FF), 1'b0, 16'h0, mk(11'd5, 16'h000F, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("sll4",       1'b1, 1'b1, ins(SLL, 11'd4),    1'b0, 16'h0, mk(11'd6, 16'h00F0, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("ldi_neg",    1'b1, 1'b1, ins(LDI, 11'h400),  1'b0, 16'h0, mk(11'd7, 16'hFC00, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("sll5",       1'b1, 1'b1, ins(SLL, 11'd5),    1'b0, 16'h0, mk(11'd8, 16'h8000, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("sra8",       1'b1, 1'b1, ins(SRA, 11'd8),    1'b0, 16'h0, mk(11'd9, 16'hFF80, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("srl4",       1'b1, 1'b1, ins(SRL, 11'd4),    1'b0, 16'h0, mk(11'd10, 16'h0FF8, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    // store with a slow RAM, then loads and ALU-mem ops
    step("sto_enter",  1'b1, 1'b1, ins(STO, 11'h010),  1'b0, 16'h0, mk(11'd10, 16'h0FF8, 1'b0, 1'b0, 1'b1, 10'h010, 16'h0FF8));
    for (int i = 0; i < 3; i++)
      step("sto_wait", 1'b1, 1'b1, ins(STO, 11'h010),  1'b0, 16'h0, mk(11'd10, 16'h0FF8, 1'b0, 1'b0, 1'b1, 10'h010, 16'h0FF8));
    step("sto_done",   1'b1, 1'b1, ins(STO, 11'h010),  1'b1, 16'h0, mk(11'd11, 16'h0FF8, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("ld_enter",   1'b1, 1'b1, ins(LD, 11'h010),   1'b1, 16'h1234, mk(11'd11, 16'h0FF8, 1'b0, 1'b1, 1'b0, 10'h010, 16'h0));
    step("ld_done",    1'b1, 1'b1, ins(LD, 11'h010),   1'b1, 16'h1234, mk(11'd12, 16'h1234, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("add_enter",  1'b1, 1'b1, ins(ADD, 11'h3FF),  1'b1, 16'h0001, mk(11'd12, 16'h1234, 1'b0, 1'b1, 1'b0, 10'h3FF, 16'h0));
    step("add_done",   1'b1, 1'b1, ins(ADD, 11'h3FF),  1'b1, 16'h0001, mk(11'd13, 16'h1235, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    // branches and PC wrap
    step("ldi0",       1'b1, 1'b1, ins(LDI, 11'd0),    1'b0, 16'h0, mk(11'd14, 16'h0000, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("beq_taken",  1'b1, 1'b1, ins(BEQ, 11'h100),  1'b0, 16'h0, mk(11'h100, 16'h0000, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("ldi1",       1'b1, 1'b1, ins(LDI, 11'd1),    1'b0, 16'h0, mk(11'h101, 16'h0001, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("beq_not",    1'b1, 1'b1, ins(BEQ, 11'h100),  1'b0, 16'h0, mk(11'h102, 16'h0001, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("bne_taken",  1'b1, 1'b1, ins(BNE, 11'h005),  1'b0, 16'h0, mk(11'h005, 16'h0001, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("jmp_top",    1'b1, 1'b1, ins(JMP, 11'h7FF),  1'b0, 16'h0, mk(11'h7FF, 16'h0001, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("nop_wrap",   1'b1, 1'b1, ins(NOP, 11'h0),    1'b0, 16'h0, mk(11'h000, 16'h0001, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    // clock enable low during MEM and RUN
    step("ldv_enter",  1'b1, 1'b1, ins(LD, 11'h020),   1'b0, 16'h0, mk(11'd0, 16'h0001, 1'b0, 1'b1, 1'b0, 10'h020, 16'h0));
    step("ldv_stall",  1'b1, 1'b0, ins(LD, 11'h020),   1'b1, 16'hBEEF, mk(11'd0, 16'h0001, 1'b0, 1'b1, 1'b0, 10'h020, 16'h0));
    step("ldv_done",   1'b1, 1'b1, ins(LD, 11'h020),   1'b1, 16'hBEEF, mk(11'd1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("run_vlow",   1'b1, 1'b0, ins(LDI, 11'd7),    1'b0, 16'h0, mk(11'd1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    // reset during a pending store
    step("stor_enter", 1'b1, 1'b1, ins(STO, 11'h011),  1'b0, 16'h0, mk(11'd1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 10'h011, 16'hBEEF));
    step("rst_midmem", 1'b0, 1'b1, ins(STO, 11'h011),  1'b1, 16'h0, mk(11'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    // halt and recovery through reset
    step("ldi3",       1'b1, 1'b1, ins(LDI, 11'd3),    1'b0, 16'h0, mk(11'd1, 16'h0003, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("hlt",        1'b1, 1'b1, ins(HLT, 11'd0),    1'b0, 16'h0, mk(11'd1, 16'h0003, 1'b1, 1'b0, 1'b0, 10'h0, 16'h0));
    for (int i = 0; i < 10; i++)
      step("halt_frz", 1'b1, 1'b1, (i % 2 == 0) ? ins(LDI, 11'd9) : ins(STO, 11'h001), 1'b1, 16'h5555,
           mk(11'd1, 16'h0003, 1'b1, 1'b0, 1'b0, 10'h0, 16'h0));
    step("rst_halt",   1'b0, 1'b1, ins(LDI, 11'd9),    1'b0, 16'h0, mk(11'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("ldi2",       1'b1, 1'b1, ins(LDI, 11'd2),    1'b0, 16'h0, mk(11'd1, 16'h0002, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("ori_f0",     1'b1, 1'b1, ins(ORI, 11'h0F0),  1'b0, 16'h0, mk(11'd2, 16'h00F2, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("and_enter",  1'b1, 1'b1, ins(AND, 11'h005),  1'b0, 16'h0, mk(11'd2, 16'h00F2, 1'b0, 1'b1, 1'b0, 10'h005, 16'h0));
    step("and_done",   1'b1, 1'b1, ins(AND, 11'h005),  1'b1, 16'h00F0, mk(11'd3, 16'h00F0, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    step("sub_enter",  1'b1, 1'b1, ins(SUB, 11'h006),  1'b0, 16'h0, mk(11'd3, 16'h00F0, 1'b0, 1'b1, 1'b0, 10'h006, 16'h0));
    step("sub_done",   1'b1, 1'b1, ins(SUB, 11'h006),  1'b1, 16'h00F1, mk(11'd4, 16'hFFFF, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
